// File: rtl/upower_multicycle_ctrl.sv
// upower_multicycle_ctrl
//   Multi-cycle sequencer for the uPOWER datapath. Steps each instruction
//   through FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the
//   per-state datapath enables. A single memory port is shared between
//   instruction fetch (iord=0) and load/store (iord=1).
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   run                 allow a new fetch to start; 0 parks the FSM in FETCH
//   instr_in[31:0]      instruction word presented by memory during fetch
//   mem_ack             memory access completes this cycle
//   zero_flag           ALU zero; consumed by the datapath branch logic
//   mem_req/mem_we/iord memory request, write strobe, address select
//   ir_write/pc_write   latch IR and PC+4 on the fetch handshake
//   pc_write_cond,beq,bne  conditional branch update and its sense
//   reg_write..reg2     register file / ALU operand controls
//   alu_op[3:0]         0010 add, 0000 and, 0001 or, 0110 sub
//   state[2:0]          current FSM state
//   illegal             sticky trap flag (illegal opcode or memory timeout)
//   retired[CNT_W-1:0]  retired-instruction count, wraps
module upower_multicycle_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15,
  parameter int TO_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [31:0]      instr_in,
  input  logic             mem_ack,
  input  logic             zero_flag,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             beq,
  output logic             bne,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             reg1,
  output logic             reg2,
  output logic [3:0]       alu_op,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    OP_ILL, OP_LD, OP_STD, OP_ADDI, OP_ANDI, OP_ORI,
    OP_ADD, OP_AND, OP_BEQ, OP_BNE
  } op_e;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [5:0]       opc_q, opc_d;
  logic [9:0]       xo_q, xo_d;
  logic [TO_W-1:0]  to_q, to_d, to_inc;
  logic [CNT_W-1:0] ret_q, ret_d;
  logic             ill_q, ill_d;
  logic             retire;
  logic             to_expire;
  op_e              op;

  // The branch compare and the unused instruction fields are resolved in
  // the datapath; the sequencer only needs opcode and XO.
  logic unused_in;
  assign unused_in = ^{zero_flag, instr_in[25:11], instr_in[0]};

  assign to_inc    = to_q + TO_W'(1);
  assign to_expire = (to_inc == TO_LIM);

  // Instruction class from the latched opcode/XO. Decoded continuously so
  // EXEC/MEM/WB can all derive their controls from the same source.
  always_comb begin
    op = OP_ILL;
    case (opc_q)
      6'd58: op = OP_LD;
      6'd62: op = OP_STD;
      6'd14: op = OP_ADDI;
      6'd28: op = OP_ANDI;
      6'd24: op = OP_ORI;
      6'd16: op = OP_BEQ;
      6'd20: op = OP_BNE;
      6'd31: begin
        if (xo_q == 10'd266)     op = OP_ADD;
        else if (xo_q == 10'd28) op = OP_AND;
        else                     op = OP_ILL;
      end
      default: op = OP_ILL;
    endcase
  end

  // ALU/operand controls are set in EXEC and held through MEM and WB so the
  // datapath sees a stable result while memory and write-back complete.
  always_comb begin
    alu_op  = 4'b0000;
    alu_src = 1'b0;
    reg_dst = 1'b0;
    reg1    = 1'b0;
    reg2    = 1'b0;
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      case (op)
        OP_LD, OP_STD, OP_ADDI: begin
          alu_op  = 4'b0010;
          alu_src = 1'b1;
        end
        OP_ANDI: begin
          alu_op  = 4'b0000;
          alu_src = 1'b1;
          reg_dst = 1'b1;
        end
        OP_ORI: begin
          alu_op  = 4'b0001;
          alu_src = 1'b1;
          reg_dst = 1'b1;
        end
        OP_ADD: begin
          alu_op = 4'b0010;
          reg2   = 1'b1;
        end
        OP_AND: begin
          alu_op = 4'b0000;
          reg2   = 1'b1;
        end
        OP_BEQ, OP_BNE: alu_op = 4'b0110;
        default: ;
      endcase
    end
  end

  // Next state and strobes.
  always_comb begin
    state_d       = state_q;
    opc_d         = opc_q;
    xo_d          = xo_q;
    to_d          = to_q;
    ill_d         = ill_q;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    beq           = 1'b0;
    bne           = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;

    case (state_q)
      S_FETCH: begin
        // run only gates the start of a fetch; acks while parked are ignored
        if (run) begin
          mem_req = 1'b1;
          if (mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            opc_d    = instr_in[31:26];
            xo_d     = instr_in[10:1];
            to_d     = '0;
            state_d  = S_DECODE;
          end else if (to_expire) begin
            ill_d   = 1'b1;
            state_d = S_TRAP;
          end else begin
            to_d = to_inc;
          end
        end
      end

      S_DECODE: begin
        if (op == OP_ILL) begin
          ill_d   = 1'b1;
          state_d = S_TRAP;
        end else begin
          state_d = S_EXEC;
        end
      end

      S_EXEC: begin
        case (op)
          OP_LD, OP_STD: begin
            to_d    = '0;
            state_d = S_MEM;
          end
          OP_BEQ, OP_BNE: begin
            pc_write_cond = 1'b1;
            beq           = (op == OP_BEQ);
            bne           = (op == OP_BNE);
            retire        = 1'b1;
            to_d          = '0;
            state_d       = S_FETCH;
          end
          default: state_d = S_WB;
        endcase
      end

      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        mem_we  = (op == OP_STD);
        if (mem_ack) begin
          to_d = '0;
          if (op == OP_STD) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (to_expire) begin
          ill_d   = 1'b1;
          state_d = S_TRAP;
        end else begin
          to_d = to_inc;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (op == OP_LD);
        retire     = 1'b1;
        to_d       = '0;
        state_d    = S_FETCH;
      end

      S_TRAP: ;  // only rst leaves TRAP

      default: state_d = S_FETCH;
    endcase
  end

  assign ret_d = retire ? ret_q + CNT_W'(1) : ret_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      opc_q   <= '0;
      xo_q    <= '0;
      to_q    <= '0;
      ret_q   <= '0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opc_q   <= opc_d;
      xo_q    <= xo_d;
      to_q    <= to_d;
      ret_q   <= ret_d;
      ill_q   <= ill_d;
    end
  end

  assign state   = state_q;
  assign illegal = ill_q;
  assign retired = ret_q;

endmodule

// File: tb/tb_upower_multicycle_ctrl.sv
// Scoreboard bench for upower_multicycle_ctrl. The driver pushes an
// expected per-instruction profile (latency, strobe counts, ALU controls,
// retire/trap outcome) computed from the instruction rules; a monitor
// measures each instruction from its fetch handshake until the FSM is back
// in FETCH or TRAP and compares against the popped profile.
module tb_upower_multicycle_ctrl;
  localparam int CW  = 4;   // small counter so retire wrap is exercised
  localparam int TMO = 15;

  logic          clk = 1'b0;
  logic          rst, run, mem_ack, zero_flag;
  logic [31:0]   instr_in;
  logic          mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond;
  logic          beq, bne, reg_write, mem_to_reg, alu_src, reg_dst, reg1, reg2;
  logic [3:0]    alu_op;
  logic [2:0]    state;
  logic          illegal;
  logic [CW-1:0] retired;

  upower_multicycle_ctrl #(.CNT_W(CW), .TIMEOUT(TMO), .TO_W(4)) dut (
    .clk(clk), .rst(rst), .run(run), .instr_in(instr_in), .mem_ack(mem_ack),
    .zero_flag(zero_flag), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .beq(beq), .bne(bne), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .reg_dst(reg_dst), .reg1(reg1), .reg2(reg2),
    .alu_op(alu_op), .state(state), .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int lat, rw, m2r, mwe, pwc, bq, bn, memc, aop, asrc, rdst, r2, ret, trap;
  } exp_t;

  exp_t          sbq[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic [CW-1:0] exp_ret = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference profile of one instruction; mw = non-ack MEM cycles before ack
  function automatic exp_t model(input logic [31:0] ins, input int mw);
    exp_t e;
    int   op, xo;
    string k;
    e  = '{default:0};
    op = int'(ins[31:26]);
    xo = int'(ins[10:1]);
    case (op)
      58: k = "ld";   62: k = "std";  14: k = "addi";
      28: k = "andi"; 24: k = "ori";  16: k = "beq";  20: k = "bne";
      31: k = (xo == 266) ? "add" : (xo == 28) ? "and" : "ill";
      default: k = "ill";
    endcase
    if (k == "ill") begin
      e.lat = 2; e.trap = 1;
    end else if (k == "beq" || k == "bne") begin
      e.lat = 3; e.pwc = 1; e.aop = 6; e.ret = 1;
      e.bq = (k == "beq") ? 1 : 0;
      e.bn = (k == "bne") ? 1 : 0;
    end else if (k == "ld" || k == "std") begin
      e.aop = 2; e.asrc = 1;
      if (mw >= TMO) begin
        e.lat = 3 + TMO; e.memc = TMO; e.trap = 1;
        e.mwe = (k == "std") ? TMO : 0;
      end else begin
        e.memc = mw + 1; e.ret = 1;
        if (k == "ld") begin
          e.lat = 5 + mw; e.rw = 1; e.m2r = 1;
        end else begin
          e.lat = 4 + mw; e.mwe = mw + 1;
        end
      end
    end else begin
      e.lat = 4; e.rw = 1; e.ret = 1;
      case (k)
        "addi": begin e.aop = 2; e.asrc = 1; end
        "andi": begin e.aop = 0; e.asrc = 1; e.rdst = 1; end
        "ori":  begin e.aop = 1; e.asrc = 1; e.rdst = 1; end
        "add":  begin e.aop = 2; e.r2 = 1; end
        default: begin e.aop = 0; e.r2 = 1; end
      endcase
    end
    return e;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    int   m_act, cyc, rw, m2r, mwe, pwc, bq, bn, memc, pcw, irw, holdbad;
    logic [3:0] c_aop;
    logic c_asrc, c_rdst, c_r1, c_r2;
    exp_t e;
    m_act = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_act   = 0;
        exp_ret = '0;
        sbq.delete();
      end else begin
        if (m_act != 0 && (state == 3'd0 || state == 3'd7)) begin
          m_act = 0;
          if (sbq.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL scoreboard: instruction completed, got none expected");
          end else begin
            e = sbq.pop_front();
            chk("latency", cyc, e.lat);
            chk("reg_write cycles", rw, e.rw);
            chk("mem_to_reg cycles", m2r, e.m2r);
            chk("mem_we cycles", mwe, e.mwe);
            chk("pc_write_cond cycles", pwc, e.pwc);
            chk("beq cycles", bq, e.bq);
            chk("bne cycles", bn, e.bn);
            chk("mem data cycles", memc, e.memc);
            chk("pc_write cycles", pcw, 1);
            chk("ir_write cycles", irw, 1);
            chk("exec alu_op", c_aop, e.aop);
            chk("exec alu_src", c_asrc, e.asrc);
            chk("exec reg_dst", c_rdst, e.rdst);
            chk("exec reg1", c_r1, 0);
            chk("exec reg2", c_r2, e.r2);
            chk("alu ctrl hold", holdbad, 0);
            chk("trap state", (state == 3'd7), e.trap);
            chk("illegal flag", illegal, e.trap);
            exp_ret = exp_ret + CW'(e.ret);
            chk("retired", retired, exp_ret);
          end
        end
        if (m_act == 0 && ir_write === 1'b1) begin
          m_act = 1; cyc = 0; rw = 0; m2r = 0; mwe = 0; pwc = 0; bq = 0; bn = 0;
          memc = 0; pcw = 0; irw = 0; holdbad = 0;
          c_aop = '0; c_asrc = 0; c_rdst = 0; c_r1 = 0; c_r2 = 0;
        end
        if (m_act != 0) begin
          cyc++;
          rw   += int'(reg_write);
          m2r  += int'(mem_to_reg);
          mwe  += int'(mem_we);
          pwc  += int'(pc_write_cond);
          bq   += int'(beq);
          bn   += int'(bne);
          pcw  += int'(pc_write);
          irw  += int'(ir_write);
          memc += int'(mem_req & iord);
          if (state == 3'd2) begin
            c_aop = alu_op; c_asrc = alu_src; c_rdst = reg_dst; c_r1 = reg1; c_r2 = reg2;
          end
          if ((state == 3'd3 || state == 3'd4) &&
              ({alu_op, alu_src, reg_dst, reg1, reg2} !== {c_aop, c_asrc, c_rdst, c_r1, c_r2}))
            holdbad++;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // fw / mw: cycles of request without ack before acking fetch / MEM
  task automatic do_instr(input logic [31:0] ins, input int fw, input int mw);
    int fc, mc;
    bit started, done;
    sbq.push_back(model(ins, mw));
    instr_in = ins;
    run      = 1'b1;
    fc = 0; mc = 0; started = 0; done = 0;
    for (int k = 0; k < 80 && !done; k++) begin
      #1;
      if (mem_req && !iord) begin
        if (fc == fw) begin mem_ack = 1'b1; started = 1; end
        else begin mem_ack = 1'b0; fc++; end
      end else if (mem_req && iord) begin
        if (mc == mw) mem_ack = 1'b1;
        else begin mem_ack = 1'b0; mc++; end
      end else begin
        // stray acks outside FETCH/MEM must be ignored
        mem_ack = started ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      zero_flag = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (started && (state == 3'd0 || state == 3'd7)) done = 1;
    end
    mem_ack = 1'b0;
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL instr timeout: ins %h did not complete, got state %0d expected 0 or 7", ins, state);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [31:0] rand_ins(input int kind);
    logic [5:0]  op;
    logic [9:0]  xo;
    logic [31:0] r;
    r  = $urandom;
    xo = r[10:1];
    case (kind)
      0: op = 6'd58;
      1: op = 6'd62;
      2: op = 6'd14;
      3: op = 6'd28;
      4: op = 6'd24;
      5: begin op = 6'd31; xo = 10'd266; end
      6: begin op = 6'd31; xo = 10'd28; end
      7: op = 6'd16;
      8: op = 6'd20;
      9: begin
        op = 6'($urandom_range(0, 63));
        if (op inside {6'd58, 6'd62, 6'd14, 6'd28, 6'd24, 6'd31, 6'd16, 6'd20}) op = 6'd1;
      end
      default: begin
        op = 6'd31;
        if (xo inside {10'd266, 10'd28}) xo = 10'd0;
      end
    endcase
    return {op, r[25:11], xo, r[0]};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    rst = 1'b1; run = 1'b0; mem_ack = 1'b0; zero_flag = 1'b0; instr_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset state", state, 0);
    chk("reset retired", retired, 0);
    chk("reset illegal", illegal, 0);
    chk("reset alu_op", alu_op, 0);
    chk("reset strobes", {mem_req, mem_we, iord, ir_write, pc_write, pc_write_cond,
                          beq, bne, reg_write, mem_to_reg, alu_src, reg_dst, reg1, reg2}, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("park state", state, 0);
    chk("park mem_req", mem_req, 0);

    do_instr(32'h3A200014, 0, 0);             // addi
    do_instr(32'hE8220004, 0, 3);             // ld, 3 wait cycles in MEM
    do_instr(32'hF8A20008, 1, 2);             // std
    do_instr(32'h7E000A14, 0, 0);             // add (X-form)
    do_instr(32'h40000008, 2, 0);             // beq
    do_instr(32'h50000008, 0, 0);             // bne

    run = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("run=0 mem_req", mem_req, 0);
      chk("run=0 state", state, 0);
    end

    do_instr(32'h3A200014, TMO - 1, 0);       // fetch ack on the last allowed cycle
    do_instr(32'hE8220004, 0, TMO - 1);       // MEM ack on the last allowed cycle
    do_instr(32'hF8A20008, TMO - 1, TMO - 1);

    do_instr(32'h7C000000 | (32'd999 << 1), 0, 0);  // XO 999 traps
    run = 1'b1;
    repeat (6) begin
      mem_ack = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      chk("trap hold state", state, 7);
      chk("trap hold illegal", illegal, 1);
      chk("trap hold retired", retired, exp_ret);
      chk("trap hold strobes", {mem_req, ir_write, pc_write, reg_write, mem_we}, 0);
    end
    apply_reset();
    chk("post-trap reset state", state, 0);
    chk("post-trap reset retired", retired, 0);
    chk("post-trap reset illegal", illegal, 0);

    // fetch timeout: 15 request cycles with no ack
    run = 1'b1; instr_in = 32'h3A200014;
    repeat (TMO - 1) @(posedge clk);
    #1;
    chk("fetch wait 14 state", state, 0);
    @(posedge clk); #1;
    chk("fetch timeout state", state, 7);
    chk("fetch timeout illegal", illegal, 1);
    apply_reset();

    do_instr(32'hE8220004, 0, 100);           // ld MEM timeout
    apply_reset();
    do_instr(32'hF8A20008, 0, 100);           // std MEM timeout
    apply_reset();

    for (int i = 0; i < 70; i++) begin
      int kind, fw, mw, gap;
      kind = int'($urandom_range(0, 10));
      fw   = int'($urandom_range(0, 4));
      mw   = ($urandom_range(0, 9) == 0) ? TMO - 1 : int'($urandom_range(0, 5));
      gap  = int'($urandom_range(0, 3));
      if (gap != 0) begin
        run = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      do_instr(rand_ins(kind), fw, mw);
      if (state == 3'd7) apply_reset();
    end

    run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    n_fail++;
    $display("FAIL watchdog: got still running expected finished");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/upower_multicycle_ctrl.md
Name: upower_multicycle_ctrl

Overview:
- Multi-cycle sequencer for the uPOWER datapath (RegFile, ALU_64, DataMemory, PC).
- Replaces single-cycle combinational decode with an FSM that drives per-state enables. One shared memory port serves both fetch and load/store.
- Sits between the memory/IR and the datapath muxes. Latches opcode and XO at fetch, then steps FETCH→DECODE→EXEC→MEM→WB.
- Counts retired instructions and traps illegal opcodes and memory timeouts.

Parameters:
- CNT_W, 32, width of retired-instruction counter
- TIMEOUT, 15, max cycles to wait for mem_ack before trap (must be ≥1)
- TO_W, 4, width of timeout counter (must satisfy 2^TO_W > TIMEOUT)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  reset, synchronous, active-high
- run  input  1  allow leaving FETCH; when 0, FSM idles in FETCH with no mem_req
- instr_in  input  32  memory read data at fetch (instruction word)
- mem_ack  input  1  memory access complete this cycle
- zero_flag  input  1  ALU zero from datapath
- mem_req  output  1  memory access request
- mem_we  output  1  memory write (std)
- iord  output  1  0 = address from PC, 1 = address from ALU result
- ir_write  output  1  latch instruction register
- pc_write  output  1  unconditional PC update (PC+4)
- pc_write_cond  output  1  PC ← branch target if branch condition holds
- beq  output  1  branch-on-zero select
- bne  output  1  branch-on-nonzero select
- reg_write, mem_to_reg, alu_src, reg_dst, reg1, reg2  output  1 each  datapath controls
- alu_op  output  4  0010 add, 0000 and, 0001 or, 0110 sub
- state  output  3  current state encoding
- illegal  output  1  sticky trap flag
- retired  output  CNT_W  retired-instruction count

Behaviour:
- Reset:
  - state = FETCH (0).
  - All control outputs = 0; alu_op = 0000; illegal = 0; retired = 0; internal opcode/XO = 0; timeout counter = 0.
  - Reset wins over every other event, including mid-instruction and in TRAP.
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7.
- FETCH:
  - If run=1: assert mem_req, iord=0.
  - On mem_ack: ir_write=1 and pc_write=1 in the same cycle; latch instr_in[31:26] and instr_in[10:1]; go to DECODE.
  - Otherwise stay in FETCH; timeout counter increments each waiting cycle.
- DECODE (one cycle):
  - Classify the latched opcode:
    - 58 = ld
    - 62 = std
    - 14 = addi
    - 28 = andi
    - 24 = ori
    - 31 = X-form: XO 266 = add, XO 28 = and
    - 16 = beq
    - 20 = bne
  - Any other opcode, or opcode 31 with any other XO → TRAP.
- EXEC:
  - ld/std/addi: alu_op=0010, alu_src=1.
  - andi: alu_op=0000, alu_src=1, reg_dst=1, reg1=0.
  - ori: alu_op=0001, alu_src=1, reg_dst=1, reg1=0.
  - add/and: alu_src=0, reg2=1, alu_op=0010 or 0000 respectively.
  - ld/std → MEM. ALU ops → WB.
  - beq/bne: alu_op=0110, pc_write_cond=1, beq or bne=1 for that one cycle; retire; → FETCH.
- MEM:
  - mem_req=1, iord=1, mem_we=1 for std; ALU controls held from EXEC.
  - Wait for mem_ack.
  - std on ack: retire, → FETCH.
  - ld on ack: → WB.
- WB (one cycle): reg_write=1; mem_to_reg=1 for ld; ALU controls held; retire; → FETCH.
- Retire: retired increments by 1, wrapping modulo 2^CNT_W.
- Latency from FETCH ack, in cycles including the fetch-ack cycle:
  - beq/bne: 3
  - std: 3 + MEM wait
  - ALU ops: 4
  - ld: 4 + MEM wait
- Timeout counter:
  - Clears on entering FETCH or MEM and on every ack.
  - Counts only while mem_req=1 and mem_ack=0.
  - Reaching TIMEOUT with no ack → TRAP; an ack on that same cycle takes priority.
- TRAP:
  - illegal=1; all strobes 0.
  - Stays in TRAP until rst; retired frozen.
- run=0 only gates the start of a fetch. An instruction already in flight completes normally.
- mem_ack outside FETCH/MEM is ignored.

Test Plan:
- rst=1 for 2 cycles, then run=1, instr_in=0x3A200014 (addi R17,R0,20), ack each fetch → states 0,1,2,4,0; alu_op=0010, alu_src=1 in EXEC; reg_write=1 only in WB; retired=1.
- ld 0xE8220004 with ack delayed 3 cycles in MEM → mem_req+iord held 4 cycles, mem_to_reg=1 and reg_write=1 in WB; retired increments once.
- std 0xF8A20008 → mem_we=1 only in MEM; no reg_write; returns to FETCH after ack.
- X-form add 0x7E000A14, then XO=999 → add gives reg2=1, alu_op=0010; XO=999 gives illegal=1, state=7; stays in TRAP until rst, which returns to FETCH with retired=0.
- beq with zero_flag=1 → pc_write_cond=1, beq=1 in EXEC only; 3-cycle latency; run=0 afterwards parks FETCH with mem_req=0.
- No mem_ack for TIMEOUT=15 cycles in FETCH → TRAP exactly on cycle 15. Repeat with ack on cycle 15 → proceeds to DECODE.
